ad9648_spi_responder: RTL
=========================

Name: ad9648_spi_responder

Overview:
- Synthesizable 3-wire SPI responder that emulates the AD9648 serial port: CS, SCLK and a bidirectional SDIO line.
- Answers the SPI master in the ADC controller for FPGA loopback and bring-up tests, so configuration sequences can be exercised without the physical ADC.
- Holds a small 8-bit register bank, decodes AD9648-style 16-bit instruction headers, and serves single-byte, multi-byte and streaming reads and writes.
- Runs entirely on the system clock: SPI pins are oversampled, not used as clocks.

Parameters:
- NumRegs, 16, number of implemented 8-bit registers at addresses 0..NumRegs-1.
- ChipId, 8'h88, read-only content of address 0x01.
- SyncStages, 2, synchronizer depth on cs_i, sck_i and sdio_i (minimum 2).

Ports:
- clk_sys_i  in  1  system clock.
- rst_sys_clk_i  in  1  synchronous active-high reset.
- cs_i  in  1  chip select, active low, asynchronous to clk_sys_i.
- sck_i  in  1  SPI clock, CPOL=0/CPHA=0.
- sdio_i  in  1  SDIO pad input (IOBUF O).
- sdio_o  out  1  SDIO drive value (IOBUF I).
- sdio_t_o  out  1  tristate control (IOBUF T): 1 = input, 0 = drive.
- reg_wr_o  out  1  one-cycle pulse per committed write byte.
- reg_addr_o  out  13  address of the committed byte.
- reg_wdata_o  out  8  data of the committed byte.
- busy_o  out  1  frame in progress (synchronized CS low).
- frame_err_o  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset values: sdio_t_o=1, sdio_o=0, reg_wr_o=0, reg_addr_o=0, reg_wdata_o=0, busy_o=0, frame_err_o=0. All registers are 0x00 except 0x01, which reads ChipId.
- Input handling: inputs pass through SyncStages flops. The block detects rising and falling edges of the synchronized sck and the falling and rising edges of the synchronized cs. SCLK high and low times must each be at least 4 clk_sys_i cycles.
- Frame format: MSB first.
  - Bit 15 is R/W (1 = read).
  - Bits 14:13 are W1:W0: 00, 01 and 10 transfer 1, 2 and 3 bytes; 11 means streaming until CS rises.
  - Bits 12:0 are the start address.
  - Data bytes follow the header.
- Address handling: the address decrements after every byte, and 0x0000 wraps to 0x1FFF.
- Sampling: sdio_i is sampled on each synchronized sck rising edge.
- State machine: IDLE -> HEADER -> WRITE or READ -> DONE.
  - IDLE: sdio_t_o=1. A cs falling edge clears the bit counter and enters HEADER.
  - HEADER: 16 rising edges are shifted in, then the block goes to WRITE (R/W=0) or READ (R/W=1).
  - WRITE: every 8th rising edge commits a byte. If the address is below NumRegs and is not 0x01, the register is updated. In every case reg_wr_o pulses one cycle later with reg_addr_o and reg_wdata_o. Once the byte count reaches W+1 (non-streaming), the block moves to DONE.
  - READ: on the sck falling edge after the 16th header rising edge, sdio_t_o goes to 0 and sdio_o drives bit 7 of the addressed byte. Each later falling edge shifts out the next bit. After the last bit of a byte, the next byte is loaded from the decremented address. After byte W+1 (non-streaming), sdio_t_o returns to 1 on the next falling edge, then the block moves to DONE.
  - Unimplemented addresses read 0x00.
  - DONE: rising sck edges are ignored and sdio_t_o=1 until CS rises.
- CS rising edge in any state: go to IDLE, set sdio_t_o=1 in the same cycle, and discard any partial byte. frame_err_o pulses if the header was incomplete or a data byte was partial. A completed non-streaming frame, or a streaming frame ending on a byte boundary, gives no error.
- A cs falling edge while not in IDLE (glitch) restarts HEADER.
- Reset mid-frame: all state returns to reset values and register contents reset. The remainder of the frame is ignored until the next CS falling edge.

Test Plan:
- Reset, then single read of 0x0001 (header 0x8001) -> sdio_t_o falls after the 16th bit, returned byte 0x88, sdio_t_o=1 after the 8th data bit, no frame_err_o.
- Write 0x5A to 0x0005 (header 0x0005), then read it back -> one reg_wr_o pulse with addr 0x0005 / data 0x5A, readback 0x5A.
- 3-byte write, header 0x4003, data 0x11 0x22 0x33 -> reg_wr_o pulses at 0x0003, 0x0002, 0x0001; registers 3=0x11 and 2=0x22; register 1 still 0x88.
- Streaming read (header 0xE000) for 3 bytes -> addresses 0x0000, 0x1FFF, 0x1FFE read 0x00, 0x00, 0x00 (wrap); no error on clean CS rise.
- CS deasserted after 10 header bits -> frame_err_o pulses once, state IDLE, no reg_wr_o, sdio_t_o stays 1.
- rst_sys_clk_i asserted during the data phase of a read -> sdio_t_o=1 the next cycle, registers cleared; a following frame on the next CS falling edge decodes correctly.

Source files
------------

// File: rtl/ad9648_spi_responder.sv
// AD9648-style 3-wire SPI responder with a small 8-bit register bank.
// The SPI pins are oversampled on clk_sys_i; nothing else is used as a clock.
module ad9648_spi_responder #(
    parameter int          NumRegs    = 16,
    parameter logic [7:0]  ChipId     = 8'h88,
    parameter int          SyncStages = 2
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_clk_i,
    input  logic        cs_i,
    input  logic        sck_i,
    input  logic        sdio_i,
    output logic        sdio_o,
    output logic        sdio_t_o,
    output logic        reg_wr_o,
    output logic [12:0] reg_addr_o,
    output logic [7:0]  reg_wdata_o,
    output logic        busy_o,
    output logic        frame_err_o
);

    localparam int          IdxW     = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam logic [12:0] NumRegsA = 13'(NumRegs);
    localparam logic [12:0] ChipAddr = 13'h0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    logic [SyncStages-1:0] cs_sync_q, cs_sync_d;
    logic [SyncStages-1:0] sck_sync_q, sck_sync_d;
    logic [SyncStages-1:0] sdio_sync_q, sdio_sync_d;
    logic                  cs_prev_q, cs_prev_d;
    logic                  sck_prev_q, sck_prev_d;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [15:0] shift_q, shift_d;
    logic [1:0]  w_q, w_d;
    logic [12:0] addr_q, addr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        last_q, last_d;
    logic        sdio_q, sdio_d;
    logic        sdio_t_q, sdio_t_d;
    logic        reg_wr_q, reg_wr_d;
    logic [12:0] reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic        busy_q, busy_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  reg_bank_q [NumRegs];
    logic [7:0]  reg_bank_d [NumRegs];

    logic        cs_s, sck_s, sdio_s;
    logic        cs_fall_s, cs_rise_s, sck_rise_s, sck_fall_s;
    logic [15:0] shift_in_s;
    logic [7:0]  rd_data_s;
    logic        wr_hit_s;

    assign cs_s       = cs_sync_q[SyncStages-1];
    assign sck_s      = sck_sync_q[SyncStages-1];
    assign sdio_s     = sdio_sync_q[SyncStages-1];
    assign cs_fall_s  = cs_prev_q & ~cs_s;
    assign cs_rise_s  = ~cs_prev_q & cs_s;
    assign sck_rise_s = ~sck_prev_q & sck_s;
    assign sck_fall_s = sck_prev_q & ~sck_s;
    assign shift_in_s = {shift_q[14:0], sdio_s};
    assign wr_hit_s   = (addr_q < NumRegsA) && (addr_q != ChipAddr);

    // Read mux: address 1 is the fixed chip ID, out-of-range addresses read zero.
    always_comb begin
        if (addr_q == ChipAddr) begin
            rd_data_s = ChipId;
        end else if (addr_q < NumRegsA) begin
            rd_data_s = reg_bank_q[addr_q[IdxW-1:0]];
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Next-state logic for synchronizers, frame FSM, register bank and outputs.
    always_comb begin
        cs_sync_d   = {cs_sync_q[SyncStages-2:0], cs_i};
        sck_sync_d  = {sck_sync_q[SyncStages-2:0], sck_i};
        sdio_sync_d = {sdio_sync_q[SyncStages-2:0], sdio_i};
        cs_prev_d   = cs_s;
        sck_prev_d  = sck_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_idx_d    = tx_idx_q;
        shift_d     = shift_q;
        w_d         = w_q;
        addr_d      = addr_q;
        byte_cnt_d  = byte_cnt_q;
        tx_byte_d   = tx_byte_q;
        last_d      = last_q;
        sdio_d      = sdio_q;
        sdio_t_d    = sdio_t_q;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        frame_err_d = 1'b0;
        reg_bank_d  = reg_bank_q;

        if (cs_rise_s) begin
            state_d  = ST_IDLE;
            sdio_t_d = 1'b1;
            sdio_d   = 1'b0;
            last_d   = 1'b0;
            // Only a short header or a byte cut mid-way is a malformed frame.
            case (state_q)
                ST_HEADER:        frame_err_d = 1'b1;
                ST_WRITE, ST_READ: frame_err_d = (bit_cnt_q != 4'd0);
                default:          frame_err_d = 1'b0;
            endcase
        end else if (cs_fall_s) begin
            state_d   = ST_HEADER;
            bit_cnt_d = 4'd0;
            sdio_t_d  = 1'b1;
            sdio_d    = 1'b0;
            last_d    = 1'b0;
        end else begin
            case (state_q)
                ST_HEADER: begin
                    if (sck_rise_s) begin
                        shift_d   = shift_in_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            w_d        = shift_in_s[14:13];
                            addr_d     = shift_in_s[12:0];
                            byte_cnt_d = 2'd0;
                            tx_idx_d   = 3'd0;
                            last_d     = 1'b0;
                            state_d    = shift_in_s[15] ? ST_READ : ST_WRITE;
                        end else begin
                            state_d = ST_HEADER;
                        end
                    end else begin
                        state_d = ST_HEADER;
                    end
                end
                ST_WRITE: begin
                    if (sck_rise_s) begin
                        shift_d = shift_in_s;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d   = 4'd0;
                            reg_wr_d    = 1'b1;
                            reg_addr_d  = addr_q;
                            reg_wdata_d = shift_in_s[7:0];
                            if (wr_hit_s) begin
                                reg_bank_d[addr_q[IdxW-1:0]] = shift_in_s[7:0];
                            end else begin
                                reg_bank_d = reg_bank_q;
                            end
                            addr_d     = addr_q - 13'd1;
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if ((w_q != 2'b11) && (byte_cnt_q == w_q)) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_WRITE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                ST_READ: begin
                    // Rising edges only track byte alignment; data moves on falling edges.
                    if (sck_rise_s) begin
                        bit_cnt_d = (bit_cnt_q == 4'd7) ? 4'd0 : bit_cnt_q + 4'd1;
                    end else if (sck_fall_s) begin
                        if (last_q) begin
                            sdio_t_d = 1'b1;
                            sdio_d   = 1'b0;
                            last_d   = 1'b0;
                            state_d  = ST_DONE;
                        end else begin
                            sdio_t_d = 1'b0;
                            if (tx_idx_q == 3'd0) begin
                                sdio_d    = rd_data_s[7];
                                tx_byte_d = {rd_data_s[6:0], 1'b0};
                            end else begin
                                sdio_d    = tx_byte_q[7];
                                tx_byte_d = {tx_byte_q[6:0], 1'b0};
                            end
                            tx_idx_d = tx_idx_q + 3'd1;
                            if (tx_idx_q == 3'd7) begin
                                addr_d     = addr_q - 13'd1;
                                byte_cnt_d = byte_cnt_q + 2'd1;
                                last_d     = (w_q != 2'b11) && (byte_cnt_q == w_q);
                            end else begin
                                addr_d = addr_q;
                            end
                        end
                    end else begin
                        state_d = ST_READ;
                    end
                end
                ST_DONE: begin
                    sdio_t_d = 1'b1;
                    state_d  = ST_DONE;
                end
                default: begin
                    sdio_t_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // All state, including the register bank, resets synchronously.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_clk_i) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= '0;
            sdio_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            tx_idx_q    <= 3'd0;
            shift_q     <= 16'h0000;
            w_q         <= 2'b00;
            addr_q      <= 13'h0000;
            byte_cnt_q  <= 2'd0;
            tx_byte_q   <= 8'h00;
            last_q      <= 1'b0;
            sdio_q      <= 1'b0;
            sdio_t_q    <= 1'b1;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= 13'h0000;
            reg_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            reg_bank_q  <= '{default: 8'h00};
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            sdio_sync_q <= sdio_sync_d;
            cs_prev_q   <= cs_prev_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_idx_q    <= tx_idx_d;
            shift_q     <= shift_d;
            w_q         <= w_d;
            addr_q      <= addr_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_byte_q   <= tx_byte_d;
            last_q      <= last_d;
            sdio_q      <= sdio_d;
            sdio_t_q    <= sdio_t_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            reg_bank_q  <= reg_bank_d;
        end
    end

    assign sdio_o      = sdio_q;
    assign sdio_t_o    = sdio_t_q;
    assign reg_wr_o    = reg_wr_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign busy_o      = busy_q;
    assign frame_err_o = frame_err_q;

endmodule
